// File: rtl/eth_rx_ingress.sv
// Per-port RX ingress: FCS check, 128-bit header entry and FCS-stripped body to the switch FIFOs.
// Body bytes leave 5 bytes behind the wire; space is checked only at frame start (no mid-frame backpressure).
module eth_rx_ingress #(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         MIN_LEN = 64,
    parameter int         MAX_LEN = 1518
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         rx_er,
    output logic [127:0] h_fifo_din,
    output logic         h_fifo_wren,
    input  logic         h_fifo_full,
    output logic [7:0]   b_fifo_din,
    output logic         b_fifo_del,
    output logic         b_fifo_wren,
    input  logic         b_fifo_afull,
    output logic [15:0]  drop_cnt,
    output logic [15:0]  err_cnt
);
    localparam logic [10:0] OVER_LEN = 11'(MAX_LEN + 1);
    localparam logic [10:0] MIN_N    = 11'(MIN_LEN);
    localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

    typedef enum logic [1:0] {S_IDLE, S_RX, S_DROP, S_END} state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] n_next;
    logic [7:0]  sr [5];
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    logic        err_seen;
    logic        accept;
    logic        ctrl;
    logic        frame_ok;

    always_comb begin
        crc_next = crc ^ {24'd0, rx_data};
        for (int i = 0; i < 8; i++)
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB88320) : (crc_next >> 1);
    end

    assign n_next   = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign accept   = rx_valid && ((state == S_IDLE && !h_fifo_full && !b_fifo_afull) ||
                                   (state == S_RX && n_next != OVER_LEN));
    assign ctrl     = (dst[47:8] == 40'h0180C20000);
    assign frame_ok = (crc == RESIDUE) && !err_seen && (cnt >= MIN_N);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [127:0] hdr(input logic valid);
        return {12'd0, valid, ctrl, PORT_ID, dst, src, typ};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            for (int i = 0; i < 5; i++) sr[i] <= '0;
            crc         <= '1;
            dst         <= '0;
            src         <= '0;
            typ         <= '0;
            err_seen    <= 1'b0;
            h_fifo_din  <= '0;
            h_fifo_wren <= 1'b0;
            b_fifo_din  <= '0;
            b_fifo_del  <= 1'b0;
            b_fifo_wren <= 1'b0;
            drop_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            h_fifo_wren <= 1'b0;
            b_fifo_wren <= 1'b0;
            b_fifo_del  <= 1'b0;

            if (accept) begin
                cnt   <= n_next;
                sr[0] <= rx_data;
                for (int i = 1; i < 5; i++) sr[i] <= sr[i-1];
                crc      <= crc_next;
                err_seen <= err_seen | rx_er;
                if (n_next <= 11'd6)       dst <= {dst[39:0], rx_data};
                else if (n_next <= 11'd12) src <= {src[39:0], rx_data};
                else if (n_next <= 11'd14) typ <= {typ[7:0], rx_data};
                // sr[4] is byte n-5 here, so the last 4 bytes (FCS) never leave
                if (n_next >= 11'd20) begin
                    b_fifo_din  <= sr[4];
                    b_fifo_wren <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (h_fifo_full || b_fifo_afull) begin
                            drop_cnt <= sat_inc(drop_cnt);
                            state    <= S_DROP;
                        end else begin
                            state <= S_RX;
                        end
                    end
                end
                S_RX: begin
                    if (rx_valid) begin
                        if (n_next == OVER_LEN) begin
                            b_fifo_din  <= sr[4];
                            b_fifo_del  <= 1'b1;
                            b_fifo_wren <= 1'b1;
                            h_fifo_din  <= hdr(1'b0);
                            h_fifo_wren <= 1'b1;
                            err_cnt     <= sat_inc(err_cnt);
                            state       <= S_DROP;
                        end
                    end else begin
                        if (cnt >= 11'd19) begin
                            b_fifo_din  <= sr[4];
                            b_fifo_del  <= 1'b1;
                            b_fifo_wren <= 1'b1;
                            h_fifo_din  <= hdr(frame_ok);
                            h_fifo_wren <= 1'b1;
                            if (!frame_ok) err_cnt <= sat_inc(err_cnt);
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                        state <= S_END;
                    end
                end
                S_END: begin
                    cnt <= '0;
                    for (int i = 0; i < 5; i++) sr[i] <= '0;
                    crc      <= '1;
                    dst      <= '0;
                    src      <= '0;
                    typ      <= '0;
                    err_seen <= 1'b0;
                    // a byte arriving in the gap cycle is lost, so the rest of that frame is junk
                    state    <= rx_valid ? S_DROP : S_IDLE;
                end
                S_DROP: begin
                    if (!rx_valid) state <= S_END;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_rx_ingress.sv
// Bench for eth_rx_ingress: frame-level expectations queued per frame, checked every cycle on the falling edge.
module tb_eth_rx_ingress;
    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic         rx_er = 1'b0;
    logic         h_fifo_full = 1'b0;
    logic         b_fifo_afull = 1'b0;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren;
    logic [7:0]   b_fifo_din;
    logic         b_fifo_del;
    logic         b_fifo_wren;
    logic [15:0]  drop_cnt;
    logic [15:0]  err_cnt;

    always #5 clk = ~clk;

    eth_rx_ingress #(.PORT_ID(2'd2), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_er(rx_er),
        .h_fifo_din(h_fifo_din), .h_fifo_wren(h_fifo_wren), .h_fifo_full(h_fifo_full),
        .b_fifo_din(b_fifo_din), .b_fifo_del(b_fifo_del), .b_fifo_wren(b_fifo_wren),
        .b_fifo_afull(b_fifo_afull), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_h[$];
    logic [8:0]   exp_b[$];
    int           exp_drop = 0;
    int           exp_err = 0;
    logic [7:0]   frm[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] d[$], input int len);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, d[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                         input int plen, input bit bad);
        logic [31:0] c;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
        frm.push_back(typ[15:8]);
        frm.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
        c = crc32(frm, frm.size());
        for (int i = 0; i < 4; i++) frm.push_back(c[i*8 +: 8]);
        if (bad) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    endtask

    task automatic raw(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    endtask

    // What the switch must see for the frame in frm (byte b is frm[b-1]).
    task automatic predict(input bit blocked, input int er_at, input int abort_at);
        int          n = frm.size();
        int          last;
        logic [47:0] d = '0;
        logic [47:0] s = '0;
        logic [15:0] t;
        bit          v;
        if (blocked) begin
            exp_drop++;
            return;
        end
        if (abort_at > 0) begin
            for (int b = 15; b <= abort_at - 5; b++) exp_b.push_back({1'b0, frm[b-1]});
            return;
        end
        if (n < 19) begin
            exp_err++;
            return;
        end
        for (int i = 0; i < 6; i++) begin
            d = {d[39:0], frm[i]};
            s = {s[39:0], frm[6+i]};
        end
        t = {frm[12], frm[13]};
        if (n > MAX_LEN) begin
            last = MAX_LEN - 4;
            v = 1'b0;
        end else begin
            last = n - 4;
            v = (crc32(frm, n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]}) && (er_at < 0) && (n >= MIN_LEN);
        end
        for (int b = 15; b <= last; b++) exp_b.push_back({(b == last), frm[b-1]});
        exp_h.push_back({12'd0, v, (d[47:8] == 40'h0180C20000), 2'd2, d, s, t});
        if (!v) exp_err++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit hf, input bit af, input int er_at, input int abort_at);
        for (int i = 0; i < frm.size(); i++) begin
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_er    = (i == er_at);
            if (i == 0) begin
                h_fifo_full  = hf;
                b_fifo_afull = af;
            end else begin
                h_fifo_full  = ($urandom_range(0, 7) == 0);
                b_fifo_afull = ($urandom_range(0, 7) == 0);
            end
            step();
            if (abort_at > 0 && i + 1 == abort_at) begin
                rx_valid = 1'b0;
                rx_er    = 1'b0;
                rst_n    = 1'b0;
                step();
                step();
                rst_n    = 1'b1;
                exp_err  = 0;
                exp_drop = 0;
                break;
            end
        end
        rx_valid     = 1'b0;
        rx_er        = 1'b0;
        h_fifo_full  = 1'b0;
        b_fifo_afull = 1'b0;
        repeat ($urandom_range(2, 5)) step();
        @(negedge clk);
        check("drop_cnt", drop_cnt, 128'(16'(exp_drop)));
        check("err_cnt", err_cnt, 128'(16'(exp_err)));
        step();
    endtask

    task automatic run(input bit hf, input bit af, input int er_at);
        predict(hf | af, er_at, 0);
        drive(hf, af, er_at, 0);
    endtask

    always @(negedge clk) begin
        if (b_fifo_wren) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL body_extra: got %h want no write", {b_fifo_del, b_fifo_din});
            end else begin
                check("body", {b_fifo_del, b_fifo_din}, exp_b.pop_front());
            end
        end
        if (h_fifo_wren) begin
            if (exp_h.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hdr_extra: got %h want no write", h_fifo_din);
            end else begin
                check("hdr", h_fifo_din, exp_h.pop_front());
            end
        end
        check("del_hdr_align", {b_fifo_wren & b_fifo_del, b_fifo_del & ~b_fifo_wren}, {h_fifo_wren, 1'b0});
    end

    initial begin
        int          sz;
        logic [127:0] hv;
        int          er_at;
        int          plen;
        int          mode;
        bit          hf;
        bit          af;
        logic [47:0] dst;

        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_h_din", h_fifo_din, 128'd0);
        check("rst_h_wren", h_fifo_wren, 128'd0);
        check("rst_b_din", b_fifo_din, 128'd0);
        check("rst_b_del", b_fifo_del, 128'd0);
        check("rst_b_wren", b_fifo_wren, 128'd0);
        check("rst_drop", drop_cnt, 128'd0);
        check("rst_err", err_cnt, 128'd0);
        step();
        rst_n = 1'b1;
        step();

        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        check("model_crc", crc32(frm, 9), 128'h0CBF43926);

        // 64-byte good frame
        build(48'h001122334455, 48'hAABBCCDDEE01, 16'h0800, 46, 1'b0);
        sz = exp_b.size();
        predict(1'b0, -1, 0);
        check("model_hdr_good", exp_h[exp_h.size()-1], 128'h000A001122334455AABBCCDDEE010800);
        check("model_body_cnt", exp_b.size() - sz, 128'd46);
        drive(1'b0, 1'b0, -1, 0);

        // same frame, corrupted FCS
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        predict(1'b0, -1, 0);
        check("model_hdr_badfcs", exp_h[exp_h.size()-1], 128'h0002001122334455AABBCCDDEE010800);
        drive(1'b0, 1'b0, -1, 0);
        check("err_cnt_badfcs", err_cnt, 128'd1);

        // control destination
        build(48'h0180C2000000, 48'hAABBCCDDEE01, 16'h8808, 46, 1'b0);
        predict(1'b0, -1, 0);
        hv = exp_h[exp_h.size()-1];
        check("model_hdr_ctrl", hv[127:112], 128'h000E);
        drive(1'b0, 1'b0, -1, 0);

        // afull at start drops the whole frame, next one passes
        build(48'h001122334455, 48'hAABBCCDDEE01, 16'h0800, 46, 1'b0);
        run(1'b0, 1'b1, -1);
        check("drop_cnt_afull", drop_cnt, 128'd1);
        build(48'h001122334455, 48'hAABBCCDDEE02, 16'h0800, 46, 1'b0);
        run(1'b0, 1'b0, -1);

        // oversize stream
        raw(1600);
        predict(1'b0, -1, 0);
        check("model_over_cnt", exp_b.size(), 128'd1500);
        drive(1'b0, 1'b0, -1, 0);

        // runt
        raw(12);
        run(1'b0, 1'b0, -1);

        // length boundaries: 19 bytes (one body byte) and 63 bytes (undersize)
        build(48'h001122334455, 48'hAABBCCDDEE01, 16'h0800, 1, 1'b0);
        run(1'b0, 1'b0, -1);
        build(48'h001122334455, 48'hAABBCCDDEE01, 16'h0800, 45, 1'b0);
        run(1'b0, 1'b0, -1);

        // reset mid-frame at byte 30, then a clean frame
        build(48'h001122334455, 48'hAABBCCDDEE01, 16'h0800, 46, 1'b0);
        predict(1'b0, -1, 30);
        drive(1'b0, 1'b0, -1, 30);
        build(48'h665544332211, 48'hAABBCCDDEE03, 16'h86DD, 46, 1'b0);
        run(1'b0, 1'b0, -1);

        for (int k = 0; k < 60; k++) begin
            mode = $urandom_range(0, 9);
            dst  = ($urandom_range(0, 3) == 0) ? {40'h0180C20000, 8'($urandom)} : {16'($urandom), 32'($urandom)};
            if (mode == 0) begin
                raw($urandom_range(1, 18));
            end else begin
                plen = (mode < 6) ? $urandom_range(0, 60) : ((mode < 9) ? $urandom_range(0, 400) : 1500);
                build(dst, {16'($urandom), 32'($urandom)}, 16'($urandom), plen, ($urandom_range(0, 3) == 0));
            end
            er_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, frm.size() - 1) : -1;
            hf = ($urandom_range(0, 9) == 0);
            af = ($urandom_range(0, 9) == 0);
            run(hf, af, er_at);
        end

        repeat (5) step();
        check("body_left", exp_b.size(), 128'd0);
        check("hdr_left", exp_h.size(), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
